// File: rtl/ip_fan_multi.sv
// Multi-channel fan PWM controller with AXI4-Lite register access.
// Define IP_FAN_TACH_EN to build in per-fan tachometer measurement.
module ip_fan_multi #(
  parameter int NUM_FANS    = 4,
  parameter int PWM_WIDTH   = 16,
  parameter int GATE_CYCLES = 100000000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [6:0]          S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [6:0]          S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
`ifdef IP_FAN_TACH_EN
  input  logic [NUM_FANS-1:0] fan_tach,
`endif
  output logic [NUM_FANS-1:0] fan_pwm
);

  localparam int NF = NUM_FANS;
  localparam int PW = PWM_WIDTH;

  logic          aw_rdy_q, ar_rdy_q;
  logic          b_vld_q, r_vld_q;
  logic [31:0]   r_data_q, rd_mux;
  logic          wr_en, rd_en;
  logic [4:0]    wr_word, rd_word;
  logic [31:0]   wmask;

  logic [NF-1:0] ctrl;
  logic [PW-1:0] period, period_act, cnt;
  logic [PW-1:0] duty     [NF];
  logic [PW-1:0] duty_act [NF];
  logic [NF-1:0] pwm_q;
  logic [15:0]   tach_val [NF];
  logic          wrap, load;

  assign wr_en   = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en   = ar_rdy_q & S_AXI_ARVALID;
  assign wr_word = S_AXI_AWADDR[6:2];
  assign rd_word = S_AXI_ARADDR[6:2];
  assign wmask   = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                    {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_WREADY  = aw_rdy_q;
  assign S_AXI_BVALID  = b_vld_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_RVALID  = r_vld_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = 2'b00;
  assign fan_pwm       = pwm_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], S_AXI_WDATA, wmask};

  // AXI handshakes: one-cycle ready pulses, responses held until taken
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_rdy_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      b_vld_q  <= 1'b0;
      r_vld_q  <= 1'b0;
      r_data_q <= '0;
    end else begin
      aw_rdy_q <= S_AXI_AWVALID & S_AXI_WVALID & ~b_vld_q & ~aw_rdy_q;
      ar_rdy_q <= S_AXI_ARVALID & ~r_vld_q & ~ar_rdy_q;
      if (wr_en)
        b_vld_q <= 1'b1;
      else if (S_AXI_BREADY)
        b_vld_q <= 1'b0;
      if (rd_en) begin
        r_vld_q  <= 1'b1;
        r_data_q <= rd_mux;
      end else if (S_AXI_RREADY) begin
        r_vld_q <= 1'b0;
      end
    end
  end

  // Byte-masked register writes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl   <= '0;
      period <= '0;
      for (int n = 0; n < NF; n++)
        duty[n] <= '0;
    end else if (wr_en) begin
      if (wr_word == 5'd0)
        ctrl <= (ctrl & ~wmask[NF-1:0])
              | (S_AXI_WDATA[NF-1:0] & wmask[NF-1:0]);
      if (wr_word == 5'd1)
        period <= (period & ~wmask[PW-1:0])
                | (S_AXI_WDATA[PW-1:0] & wmask[PW-1:0]);
      for (int n = 0; n < NF; n++)
        if (wr_word == 5'(n + 2))
          duty[n] <= (duty[n] & ~wmask[PW-1:0])
                   | (S_AXI_WDATA[PW-1:0] & wmask[PW-1:0]);
    end
  end

  // Read data mux, unmapped words read as zero
  always_comb begin
    rd_mux = '0;
    if (rd_word == 5'd0)
      rd_mux = 32'(ctrl);
    if (rd_word == 5'd1)
      rd_mux = 32'(period);
    for (int n = 0; n < NF; n++) begin
      if (rd_word == 5'(n + 2))
        rd_mux = 32'(duty[n]);
      if (rd_word == 5'(n + 16))
        rd_mux = 32'(tach_val[n]);
    end
  end

  assign wrap = (period_act != '0) && (cnt == period_act - PW'(1));
  assign load = wrap || (period_act == '0);

  // Shared counter, shadow reload at wrap, registered PWM compare
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt        <= '0;
      period_act <= '0;
      pwm_q      <= '0;
      for (int n = 0; n < NF; n++)
        duty_act[n] <= '0;
    end else begin
      cnt <= load ? '0 : cnt + PW'(1);
      if (load) begin
        period_act <= period;
        for (int n = 0; n < NF; n++)
          duty_act[n] <= duty[n];
      end
      for (int n = 0; n < NF; n++)
        pwm_q[n] <= ctrl[n] && (period_act != '0) && (cnt < duty_act[n]);
    end
  end

`ifdef IP_FAN_TACH_EN
  logic [NF-1:0] t_s1, t_s2, t_s3, t_rise;
  logic [31:0]   gate_cnt;
  logic          gate_end;
  logic [15:0]   t_cnt [NF];
  logic [15:0]   t_nxt [NF];

  assign t_rise   = t_s2 & ~t_s3;
  assign gate_end = gate_cnt == 32'(GATE_CYCLES - 1);

  // Saturating edge count for the current window
  always_comb begin
    for (int n = 0; n < NF; n++) begin
      t_nxt[n] = t_cnt[n];
      if (t_rise[n] && t_cnt[n] != 16'hFFFF)
        t_nxt[n] = t_cnt[n] + 16'd1;
    end
  end

  // Synchronise tach inputs, count edges, latch at window end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      t_s1     <= '0;
      t_s2     <= '0;
      t_s3     <= '0;
      gate_cnt <= '0;
      for (int n = 0; n < NF; n++) begin
        t_cnt[n]    <= '0;
        tach_val[n] <= '0;
      end
    end else begin
      t_s1     <= fan_tach;
      t_s2     <= t_s1;
      t_s3     <= t_s2;
      gate_cnt <= gate_end ? '0 : gate_cnt + 32'd1;
      for (int n = 0; n < NF; n++) begin
        if (gate_end) begin
          tach_val[n] <= t_nxt[n];
          t_cnt[n]    <= '0;
        end else begin
          t_cnt[n] <= t_nxt[n];
        end
      end
    end
  end
`else
  // No tach hardware: counts always read zero
  always_comb begin
    for (int n = 0; n < NF; n++)
      tach_val[n] = '0;
  end
`endif

endmodule

// File: tb/tb_ip_fan_multi.sv
// Directed testbench for ip_fan_multi.
// Tach checks run when IP_FAN_TACH_EN is defined.
module tb_ip_fan_multi;

  localparam int NF = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [6:0]    S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]    S_AXI_AWPROT, S_AXI_ARPROT;
  logic          S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY;
  logic          S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic [NF-1:0] fan_pwm;
`ifdef IP_FAN_TACH_EN
  logic [NF-1:0] fan_tach;
`endif

  int checks = 0;
  int errors = 0;
  int hi [NF];
  logic [1:0] bresp_last;

  always #5 ACLK = ~ACLK;

  ip_fan_multi #(
    .NUM_FANS(NF),
    .PWM_WIDTH(16),
    .GATE_CYCLES(1000)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
`ifdef IP_FAN_TACH_EN
    .fan_tach(fan_tach),
`endif
    .fan_pwm(fan_pwm)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [6:0] a,
                        input logic [31:0] d,
                        input logic [3:0] s);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_WSTRB   = s;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) check("aw_timeout", 32'(n), 32'd0);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) check("b_timeout", 32'(n), 32'd0);
    bresp_last = S_AXI_BRESP;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_rd(input logic [6:0] a,
                        output logic [31:0] d,
                        output logic [1:0] r);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) check("ar_timeout", 32'(n), 32'd0);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) check("r_timeout", 32'(n), 32'd0);
    d = S_AXI_RDATA;
    r = S_AXI_RRESP;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic sample_win(input int ncyc);
    for (int f = 0; f < NF; f++) hi[f] = 0;
    repeat (ncyc) begin
      @(negedge ACLK);
      for (int f = 0; f < NF; f++) hi[f] += int'(fan_pwm[f]);
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        prev;
    int          n, pre, mis, bv, aw;

    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_ARADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
`ifdef IP_FAN_TACH_EN
    fan_tach      = '0;
`endif
    repeat (3) @(negedge ACLK);
    check("rst_pwm", 32'(fan_pwm), 32'd0);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    ARESETN = 1'b1;
    axi_rd(7'h00, rd, rr);
    check("rst_ctrl", rd, 32'd0);
    axi_rd(7'h04, rd, rr);
    check("rst_period", rd, 32'd0);

    // 3/10 on fan 0
    axi_wr(7'h08, 32'd3, 4'hF);
    axi_wr(7'h00, 32'd1, 4'hF);
    axi_wr(7'h04, 32'd10, 4'hF);
    check("bresp_okay", 32'(bresp_last), 32'd0);
    repeat (15) @(negedge ACLK);
    sample_win(20);
    check("duty3_fan0", 32'(hi[0]), 32'd6);
    check("duty3_fan1", 32'(hi[1]), 32'd0);
    check("duty3_fan3", 32'(hi[3]), 32'd0);
    axi_rd(7'h04, rd, rr);
    check("period_rb", rd, 32'd10);

    // DUTY[1] changed mid-period takes effect at next wrap
    axi_wr(7'h00, 32'd3, 4'hF);
    prev = fan_pwm[0];
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (fan_pwm[0] && !prev) break;
      prev = fan_pwm[0];
    end while (n < 40);
    if (n >= 40) check("rise0_timeout", 32'(n), 32'd0);
    axi_wr(7'h0C, 32'd4, 4'hF);
    pre  = int'(fan_pwm[1]);
    prev = fan_pwm[0];
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (fan_pwm[0] && !prev) break;
      pre += int'(fan_pwm[1]);
      prev = fan_pwm[0];
    end while (n < 40);
    if (n >= 40) check("rise1_timeout", 32'(n), 32'd0);
    check("duty1_old_kept", 32'(pre), 32'd0);
    mis = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge ACLK);
      if (fan_pwm[1] !== ((k % 10) < 4)) mis++;
      if (fan_pwm[0] !== ((k % 10) < 3)) mis++;
    end
    check("duty1_new_pattern", 32'(mis), 32'd0);

    // Duty above period saturates high; period 0 forces low
    axi_wr(7'h10, 32'd12, 4'hF);
    axi_wr(7'h00, 32'h4, 4'hF);
    repeat (25) @(negedge ACLK);
    sample_win(20);
    check("full_fan2", 32'(hi[2]), 32'd20);
    check("full_fan0_off", 32'(hi[0]), 32'd0);
    check("full_fan1_off", 32'(hi[1]), 32'd0);
    axi_wr(7'h00, 32'hF, 4'hF);
    axi_wr(7'h04, 32'd0, 4'hF);
    repeat (25) @(negedge ACLK);
    sample_win(20);
    check("p0_fan0", 32'(hi[0]), 32'd0);
    check("p0_fan1", 32'(hi[1]), 32'd0);
    check("p0_fan2", 32'(hi[2]), 32'd0);

    // CTRL change reaches the pin without waiting for a wrap
    axi_wr(7'h04, 32'd10, 4'hF);
    axi_wr(7'h00, 32'h4, 4'hF);
    repeat (25) @(negedge ACLK);
    check("ctrl_on", 32'(fan_pwm[2]), 32'd1);
    axi_wr(7'h00, 32'h0, 4'hF);
    check("ctrl_off", 32'(fan_pwm[2]), 32'd0);

    // Byte strobes and unmapped access
    axi_wr(7'h08, 32'd0, 4'hF);
    axi_wr(7'h08, 32'hAABBCCDD, 4'h3);
    axi_rd(7'h08, rd, rr);
    check("wstrb_duty0", rd, 32'h0000CCDD);
    axi_wr(7'h08, 32'h00001111, 4'h2);
    axi_rd(7'h08, rd, rr);
    check("wstrb_byte1", rd, 32'h000011DD);
    axi_rd(7'h3C, rd, rr);
    check("unmapped_data", rd, 32'd0);
    check("unmapped_resp", 32'(rr), 32'd0);
    axi_wr(7'h7C, 32'hFFFFFFFF, 4'hF);
    axi_rd(7'h00, rd, rr);
    check("unmapped_wr_drop", rd, 32'd0);

    // Simultaneous write and read of DUTY[3]
    @(negedge ACLK);
    S_AXI_AWADDR  = 7'h14;
    S_AXI_ARADDR  = 7'h14;
    S_AXI_WDATA   = 32'h77;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("same_cyc_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check("same_cyc_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("same_cyc_pre_val", S_AXI_RDATA, 32'd0);
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    axi_rd(7'h14, rd, rr);
    check("same_cyc_post_val", rd, 32'h77);

    // AW leads W by 3 cycles, BREADY held off 5 cycles
    @(negedge ACLK);
    S_AXI_AWADDR  = 7'h14;
    S_AXI_WDATA   = 32'h55;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    aw = 0;
    repeat (3) begin
      @(negedge ACLK);
      aw += int'(S_AXI_AWREADY);
    end
    check("aw_only_no_ready", 32'(aw), 32'd0);
    S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    aw += int'(S_AXI_AWREADY);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    bv = 0;
    for (int i = 0; i < 5; i++) begin
      bv += int'(S_AXI_BVALID);
      aw += int'(S_AXI_AWREADY);
      @(negedge ACLK);
    end
    check("bvalid_held", 32'(bv), 32'd5);
    check("single_accept", 32'(aw), 32'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
    axi_rd(7'h14, rd, rr);
    check("late_w_data", rd, 32'h55);

    // Reset clears configuration
    do_reset();
    check("rst2_pwm", 32'(fan_pwm), 32'd0);
    axi_rd(7'h08, rd, rr);
    check("rst2_duty0", rd, 32'd0);

`ifdef IP_FAN_TACH_EN
    do_reset();
    for (int i = 0; i < 25; i++) begin
      fan_tach[0] = 1'b1;
      repeat (4) @(negedge ACLK);
      fan_tach[0] = 1'b0;
      repeat (4) @(negedge ACLK);
    end
    repeat (900) @(negedge ACLK);
    axi_rd(7'h40, rd, rr);
    check("tach0_25", rd, 32'd25);
    axi_rd(7'h44, rd, rr);
    check("tach1_0", rd, 32'd0);
    for (int i = 0; i < 10; i++) begin
      fan_tach[0] = 1'b1;
      repeat (4) @(negedge ACLK);
      fan_tach[0] = 1'b0;
      repeat (4) @(negedge ACLK);
    end
    do_reset();
    axi_rd(7'h40, rd, rr);
    check("tach_rst", rd, 32'd0);
`else
    axi_rd(7'h40, rd, rr);
    check("tach0_absent", rd, 32'd0);
    axi_rd(7'h4C, rd, rr);
    check("tach3_absent", rd, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
